// File: rtl/line_rasterizer_if.sv
// Command/pixel bus between a line-command source and the rasterizer.
// The pixel side maps one-to-one onto the frame buffer GPU write port.
interface line_rasterizer_if;
  logic       start;
  logic [9:0] x0;
  logic [9:0] y0;
  logic [9:0] x1;
  logic [9:0] y1;
  logic [3:0] color;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [3:0] pix_data;
  logic       pix_we;
  logic       busy;
  logic       done;

  modport master (
    output start, x0, y0, x1, y1, color,
    input  pix_x, pix_y, pix_data, pix_we, busy, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, color,
    output pix_x, pix_y, pix_data, pix_we, busy, done
  );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line engine: one pixel write per clock, off-screen pixels clipped.
//   state   | meaning
//   S_IDLE  | waiting for start, endpoints/colour latched on accept
//   S_SETUP | derive dx, dy, step directions and initial error
//   S_DRAW  | present current pixel, step toward the end point
//   S_DONE  | one-cycle done pulse, then back to idle
module line_rasterizer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input logic              Clk,
  input logic              Reset_n,
  line_rasterizer_if.slave ras
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [9:0]         x0_q, y0_q, x1_q, y1_q;
  logic [3:0]         color_q;
  logic [10:0]        dx_q;
  logic signed [11:0] dy_q;
  logic signed [11:0] err_q;
  logic               sx_neg_q, sy_neg_q;
  logic [9:0]         cur_x_q, cur_y_q;
  logic [3:0]         pix_data_q;
  logic               pix_we_q, busy_q, done_q;

  logic [10:0]        dx_d;
  logic [10:0]        ady_d;
  logic signed [11:0] dy_d;
  logic signed [11:0] err_init_d;
  logic               sx_neg_d, sy_neg_d;

  logic signed [12:0] e2;
  logic signed [12:0] dy_ext;
  logic signed [12:0] dx_ext;
  logic               step_x, step_y;
  logic signed [11:0] err_d;
  logic [9:0]         cur_x_d, cur_y_d;
  logic               at_end;

  function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
    return ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  endfunction

  // Setup terms are derived from the latched endpoints only.
  always_comb begin
    dx_d       = (x1_q >= x0_q) ? {1'b0, x1_q - x0_q} : {1'b0, x0_q - x1_q};
    ady_d      = (y1_q >= y0_q) ? {1'b0, y1_q - y0_q} : {1'b0, y0_q - y1_q};
    dy_d       = -$signed({1'b0, ady_d});
    sx_neg_d   = !(x0_q < x1_q);
    sy_neg_d   = !(y0_q < y1_q);
    err_init_d = $signed({1'b0, dx_d}) + dy_d;
  end

  // Step decision uses the pre-update error doubled into 13 bits.
  always_comb begin
    e2      = $signed({err_q, 1'b0});
    dy_ext  = {dy_q[11], dy_q};
    dx_ext  = $signed({2'b00, dx_q});
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    err_d   = err_q
            + (step_x ? dy_q : 12'sd0)
            + (step_y ? $signed({1'b0, dx_q}) : 12'sd0);
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (step_x) cur_x_d = sx_neg_q ? cur_x_q - 10'd1 : cur_x_q + 10'd1;
    if (step_y) cur_y_d = sy_neg_q ? cur_y_q - 10'd1 : cur_y_q + 10'd1;
    at_end  = (cur_x_q == x1_q) && (cur_y_q == y1_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      pix_data_q <= '0;
      pix_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ras.start) begin
            x0_q    <= ras.x0;
            y0_q    <= ras.y0;
            x1_q    <= ras.x1;
            y1_q    <= ras.y1;
            color_q <= ras.color;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          dx_q       <= dx_d;
          dy_q       <= dy_d;
          err_q      <= err_init_d;
          sx_neg_q   <= sx_neg_d;
          sy_neg_q   <= sy_neg_d;
          cur_x_q    <= x0_q;
          cur_y_q    <= y0_q;
          pix_data_q <= color_q;
          pix_we_q   <= visible(x0_q, y0_q);
          state_q    <= S_DRAW;
        end
        S_DRAW: begin
          if (at_end) begin
            pix_we_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            err_q    <= err_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            pix_we_q <= visible(cur_x_d, cur_y_d);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          pix_we_q <= 1'b0;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // The current walk position doubles as the output coordinate so it holds outside DRAW.
  assign ras.pix_x    = cur_x_q;
  assign ras.pix_y    = cur_y_q;
  assign ras.pix_data = pix_data_q;
  assign ras.pix_we   = pix_we_q;
  assign ras.busy     = busy_q;
  assign ras.done     = done_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Scoreboard bench for line_rasterizer: stimulus pushes expected pixel cycles,
// a negedge monitor pops and compares every DRAW/DONE cycle the DUT presents.
module tb_line_rasterizer;
  logic Clk = 1'b0;
  logic Reset_n = 1'b1;

  line_rasterizer_if bus();

  line_rasterizer #(.H_RES(640), .V_RES(480)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .ras     (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit is_done;
    int x;
    int y;
    bit we;
    int data;
    int count;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference walk straight from the line equations, in plain integers.
  function automatic void model(input int x0, input int y0, input int x1, input int y1, input int c);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_t e;
    dx  = iabs(x1 - x0);
    dy  = -iabs(y1 - y0);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    forever begin
      e.is_done = 1'b0;
      e.x       = x;
      e.y       = y;
      e.we      = (x < 640) && (y < 480);
      e.data    = c;
      e.count   = 0;
      expq.push_back(e);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    e.is_done = 1'b1;
    e.x       = 0;
    e.y       = 0;
    e.we      = 1'b0;
    e.data    = c;
    e.count   = ((dx > -dy) ? dx : -dy) + 1;
    expq.push_back(e);
  endfunction

  // Monitor: phase 0 idle/setup, 1 pixel cycles until done, 2 the cycle after done.
  int phase = 0;
  int npix = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      phase = 0;
      npix  = 0;
    end else begin
      case (phase)
        0: begin
          check("idle_we", bus.pix_we, 0);
          check("idle_done", bus.done, 0);
          if (bus.busy) begin
            phase = 1;
            npix  = 0;
          end
        end
        1: begin
          check("draw_busy", bus.busy, 1);
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_cycle: got x=%0d y=%0d we=%0d done=%0d, expected no activity",
                     bus.pix_x, bus.pix_y, bus.pix_we, bus.done);
            if (bus.done) phase = 2;
          end else begin
            e = expq.pop_front();
            if (bus.done) begin
              check("done_marker", e.is_done, 1);
              check("pix_count", npix, e.count);
              check("done_we", bus.pix_we, 0);
              phase = 2;
            end else begin
              check("pix_is_pixel", e.is_done, 0);
              if (!e.is_done) begin
                check("pix_x", bus.pix_x, e.x);
                check("pix_y", bus.pix_y, e.y);
                check("pix_we", bus.pix_we, e.we);
                check("pix_data", bus.pix_data, e.data);
              end
              npix++;
            end
          end
        end
        default: begin
          check("busy_after_done", bus.busy, 0);
          check("done_one_cycle", bus.done, 0);
          phase = 0;
        end
      endcase
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge Clk);
    while (bus.busy && n < budget) begin
      @(negedge Clk);
      n++;
    end
    total++;
    if (bus.busy) begin
      bad++;
      $display("FAIL idle_timeout: busy still %0d, expected 0 within %0d cycles", bus.busy, budget);
    end
  endtask

  task automatic draw(input int x0, input int y0, input int x1, input int y1, input int c);
    wait_idle(4000);
    bus.x0    = 10'(x0);
    bus.y0    = 10'(y0);
    bus.x1    = 10'(x1);
    bus.y1    = 10'(y1);
    bus.color = 4'(c);
    bus.start = 1'b1;
    model(x0, y0, x1, y1, c);
    @(negedge Clk);
    bus.start = 1'b0;
    // Endpoints must have been latched; scramble the bus behind the command.
    bus.x0    = 10'($urandom);
    bus.y0    = 10'($urandom);
    bus.x1    = 10'($urandom);
    bus.y1    = 10'($urandom);
    bus.color = 4'($urandom);
    check("busy_rise", bus.busy, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_x"}, bus.pix_x, 0);
    check({tag, "_pix_y"}, bus.pix_y, 0);
    check({tag, "_pix_data"}, bus.pix_data, 0);
    check({tag, "_pix_we"}, bus.pix_we, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    int ax, ay, bx, by, mode;
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.color = '0;
    #2 Reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b1;

    draw(5, 5, 5, 5, 4'hA);
    draw(0, 0, 3, 0, 4'h1);
    draw(0, 0, 2, 5, 4'h2);
    draw(10, 10, 7, 7, 4'h3);
    draw(636, 0, 643, 0, 4'h4);
    draw(1020, 470, 1023, 490, 4'h6);

    // Start pulsed mid-line must not disturb the line in progress.
    draw(0, 0, 20, 7, 4'h3);
    repeat (4) @(negedge Clk);
    bus.x0 = 10'd100; bus.y0 = 10'd100; bus.x1 = 10'd200; bus.y1 = 10'd50; bus.color = 4'hF;
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;

    // Reset mid-line: outputs drop at once, nothing more is written.
    draw(0, 0, 500, 100, 4'h5);
    repeat (20) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_all_zero("abort");
    expq.delete();
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b1;
    draw(3, 4, 9, 1, 4'h7);

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
          bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
        end
        1: begin
          ax = $urandom_range(600, 700); ay = $urandom_range(440, 520);
          bx = $urandom_range(600, 700); by = $urandom_range(440, 520);
        end
        2: begin
          ax = $urandom_range(0, 1023); ay = $urandom_range(0, 1023);
          bx = ax; by = ay;
        end
        default: begin
          ax = $urandom_range(0, 1000); ay = $urandom_range(0, 1000);
          bx = ax + $urandom_range(0, 23); by = ay + $urandom_range(0, 23);
        end
      endcase
      draw(ax, ay, bx, by, $urandom_range(0, 15));
    end

    wait_idle(4000);
    repeat (3) @(negedge Clk);
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Bresenham line-drawing engine that sits directly upstream of the frame buffer's GPU write port. It accepts one line command (two endpoints plus a 4-bit colour), then emits one pixel write per clock on the same x/y/data/we bus the frame buffer consumes. Pixels outside the visible raster are clipped: their cycle is still spent, but the write strobe stays low.

## Interface
- `H_RES`, 640, visible width. Pixels with x ≥ H_RES are clipped.
- `V_RES`, 480, visible height. Pixels with y ≥ V_RES are clipped.

- `Clk`  in  1  GPU clock (gpu_clk_150 domain), rising-edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe. Sampled only in IDLE.
- `x0`, `y0`  in  10 each  start endpoint, unsigned.
- `x1`, `y1`  in  10 each  end endpoint, unsigned.
- `color`  in  4  pixel value, latched with `start`.
- `pix_x`, `pix_y`  out  10 each  current pixel coordinate, to frame buffer gpu_x/gpu_y.
- `pix_data`  out  4  latched colour, to gpu_data.
- `pix_we`  out  1  write strobe, to gpu_we.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last pixel cycle.

## Operation
- **IDLE**
  - `start`=1 latches x0, y0, x1, y1 and color, then goes to SETUP.
  - Endpoints and colour are ignored in any other state.
- **SETUP** (1 cycle) computes:
  - dx = |x1−x0|, 11-bit unsigned.
  - dy = −|y1−y0|, 12-bit signed.
  - sx = +1 if x0<x1, else −1.
  - sy = +1 if y0<y1, else −1.
  - err = dx + dy, 12-bit signed.
  - cur = (x0,y0).
  - Then goes to DRAW.
- **DRAW** (one pixel per cycle):
  - Output cur. `pix_we` = (cur_x < H_RES) && (cur_y < V_RES).
  - If cur == (x1,y1), go to DONE.
  - Otherwise, with e2 = 2·err (13-bit signed) computed from the pre-update err:
    - If e2 ≥ dy: err += dy, cur_x += sx.
    - If e2 ≤ dx: err += dx, cur_y += sy.
    - Both updates apply in the same cycle when both hold.
- **DONE** (1 cycle): `done`=1, then return to IDLE.
- Arithmetic rules:
  - Signed compares on sign-extended operands.
  - cur_x/cur_y never leave the 0..1023 range, because the walk stays within the endpoint bounding box.
- Pixel count per line = max(dx, |dy|) + 1, including both endpoints.
- Degenerate line (x0,y0)==(x1,y1): exactly one pixel cycle.
- `start` while busy: ignored, no queuing, no effect on the line in progress.
- Clipped pixels: walk continues, `pix_x`/`pix_y` still update, `pix_we`=0.
- Outputs outside DRAW:
  - `pix_we`=0.
  - `pix_x`, `pix_y` and `pix_data` hold their last values.

## Timing
- All outputs driven from registers or state decode. No combinational path from inputs to outputs.
- Reset values (asynchronous, immediate on `Reset_n` low):
  - state = IDLE.
  - `pix_x`, `pix_y`, `pix_data` = 0.
  - `pix_we`, `busy`, `done` = 0.
  - Internal err, dx, dy = 0.
- `start` high in cycle N (IDLE):
  - Cycle N+1: SETUP, `busy`=1.
  - Cycles N+2 .. N+1+P: pixels, where P = pixel count.
  - Cycle N+2+P: `done`=1.
  - Cycle N+3+P: IDLE, `busy`=0, and `start` may be accepted again.
- Throughput: 1 pixel/clock, with 3 cycles of overhead per line (SETUP, DONE, IDLE sample).
- Reset mid-line:
  - Aborts immediately with no further writes.
  - `done` is not pulsed.
  - After release, the block is in IDLE.
- Frame buffer write is single-cycle with no backpressure, so no stall input is provided.

## Test plan
- **Single point** (5,5)→(5,5), color 4'hA, start at cycle 0:
  - Cycle 2: one write (5,5,A).
  - Cycle 3: `done`.
  - Cycle 4: `busy` low.
- **Horizontal** (0,0)→(3,0): `pix_we` high in cycles 2–5 with x = 0,1,2,3, y = 0, then `done` at cycle 6.
- **Steep with negative error path** (0,0)→(2,5): exactly 6 writes in order (0,0), (0,1), (1,2), (1,3), (2,4), (2,5), then `done`.
- **Reverse direction** (10,10)→(7,7): writes (10,10), (9,9), (8,8), (7,7).
- **Clipping** (636,0)→(643,0):
  - 8 pixel cycles.
  - `pix_we` high only for x = 636..639.
  - `done` at cycle 10.
- **Busy start and reset abort**:
  - Pulse `start` with different endpoints during DRAW: the current line completes unchanged.
  - Assert `Reset_n`=0 mid-line: all outputs go to 0 asynchronously and no `done` is seen.
  - A new `start` after reset draws correctly.
